buff_uart_reader: RTL and testbench
===================================

// Module: buff_uart_reader
// PURPOSE
//  Read-side engine for the ADC ping-pong buffer. On each write_done pulse it
//  walks read_addr over the completed 256-byte page. It serialises a sync byte
//  plus every page byte onto an 8N1 UART line to the host/uC, LSB first.
//  Sits beside the ADC capture top: consumes write_done/dout, drives read_addr.
// PARAMETERS
//  CLK_DIV  434   clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
//  NBYTES   256   bytes per page; read_addr walks 0..NBYTES-1
//  SYNC     8'hA5 frame header byte sent before page byte 0
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  res         in   1  asynchronous reset, active high
//  write_done  in   1  1-clk pulse: a full page is ready in the buffer
//  buf_dout    in   8  buffer read data, valid 1 clk after read_addr changes
//  read_addr   out  8  buffer read address
//  TXD         out  1  UART serial out, idle high
//  busy        out  1  high from accepted write_done until last stop bit ends
//  page_sent   out  1  1-clk pulse after the stop bit of the last page byte
//  overrun     out  1  sticky: write_done arrived while busy (cleared by res only)
// BEHAVIOUR
//  Reset values: read_addr=0, TXD=1, busy=0, page_sent=0, overrun=0, FSM=IDLE.
//  FSM states/transitions:
//   IDLE : write_done -> LOAD_SYNC, busy<=1, read_addr<=0
//   LOAD_SYNC: tx_data<=SYNC, tx_start -> SEND
//   FETCH: read_addr stable 1 clk (buffer latency) -> LATCH
//   LATCH: tx_data<=buf_dout, tx_start -> SEND
//   SEND : wait tx_done; if sent byte was SYNC or read_addr<NBYTES-1 -> NEXT,
//          else -> DONE
//   NEXT : read_addr<=read_addr+1 unless byte was SYNC -> FETCH
//   DONE : page_sent<=1 for 1 clk, busy<=0, read_addr<=0 -> IDLE
//  UART framing: start(0), d0..d7, stop(1); each bit exactly CLK_DIV clks.
//   Bit counter 4 bits, divider counter 16 bits; tx_done is a 1-clk pulse on
//   the last clk of the stop bit. Back-to-back bytes: a gap of 3 clks idle-high
//   (LATCH/FETCH/NEXT overhead) is permitted between stop and next start.
//  Frame: NBYTES+1 bytes; byte k (k>=1) = buffer[k-1]. read_addr wraps to 0
//   only via DONE, never by overflow (NBYTES=256 -> last addr 255).
//  write_done while busy: ignored for transfer, overrun<=1, current frame
//   continues unaffected. write_done same clk as DONE: treated as busy
//   (overrun set, not restarted).
//  res mid-frame: TXD forced 1 immediately (async), frame abandoned, no
//   page_sent; host sees truncated frame and resyncs on SYNC.
// STRUCTURE
//  Shared package/header: FSM state encodings, UART_BITS=10, default SYNC.
//  One sub-module: uart_tx_byte (clk,res,tx_start,tx_data[7:0] -> TXD,
//   tx_busy,tx_done), param CLK_DIV; holds divider, bit counter, shift reg.
//  Top keeps FSM, read_addr counter, overrun/page_sent flags.
// TESTING (bench: CLK_DIV=4, NBYTES=256, buffer model buf[i]=i^8'h3C, 1-clk read)
//  1 res pulse, idle 100 clks -> TXD=1, busy=0, read_addr=0, no pulses.
//  2 write_done pulse -> UART decoder captures A5,3C,3D,3E,...,C3 (257 bytes);
//    each bit 4 clks; page_sent once; busy low after; read_addr back to 0.
//  3 second write_done 500 clks into frame -> overrun=1 stays high, frame
//    bytes unchanged, exactly one page_sent, no second frame starts.
//  4 res asserted during byte 10 -> TXD=1 same cycle, busy=0, overrun=0;
//    following write_done yields a complete correct 257-byte frame.
//  5 write_done in the DONE clk -> overrun=1, no new frame; next write_done
//    after idle -> normal frame.
//  6 CLK_DIV=2 build, two consecutive pages -> both decode correctly,
//    inter-byte idle gap <=3 clks, start bit exactly 2 clks.

Source files
------------

// File: rtl/buff_uart_reader_pkg.sv
// Shared definitions for the ADC page reader and its UART transmitter.
//  - state_t      : read-side FSM state encoding
//  - UART_BITS    : bits per 8N1 character (start + 8 data + stop)
//  - SYNC_DEFAULT : frame header byte sent ahead of page byte 0
package buff_uart_reader_pkg;

  localparam int         UART_BITS    = 10;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_SYNC,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/buff_uart_reader_uart_tx.sv
// uart_tx_byte: 8N1 serialiser, LSB first, idle high.
// Ports:
//  clk      in  system clock
//  res      in  asynchronous reset, active high (forces TXD high at once)
//  tx_start in  request to send tx_data; honoured only while not busy
//  tx_data  in  byte to send, captured on the accepted tx_start
//  TXD      out serial line
//  tx_busy  out a character is in flight
//  tx_done  out 1-clk pulse on the last clk of the stop bit
module uart_tx_byte
  import buff_uart_reader_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       TXD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  BIT_LAST = 4'(UART_BITS - 1);

  logic [15:0] div_cnt_reg;
  logic [3:0]  bit_cnt_reg;
  logic [8:0]  shift_reg;   // remaining data bits with the stop bit on top
  logic        txd_reg;
  logic        busy_reg;
  logic        bit_end;

  assign bit_end = busy_reg && (div_cnt_reg == DIV_LAST);
  assign tx_done = bit_end && (bit_cnt_reg == BIT_LAST);
  assign TXD     = txd_reg;
  assign tx_busy = busy_reg;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '1;
      txd_reg     <= 1'b1;
      busy_reg    <= 1'b0;
    end else if (!busy_reg) begin
      if (tx_start) begin
        // The start bit goes out immediately; the rest waits in the shifter.
        busy_reg    <= 1'b1;
        txd_reg     <= 1'b0;
        shift_reg   <= {1'b1, tx_data};
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
      end
    end else if (bit_end) begin
      div_cnt_reg <= '0;
      if (bit_cnt_reg == BIT_LAST) begin
        busy_reg <= 1'b0;
        txd_reg  <= 1'b1;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
        txd_reg     <= shift_reg[0];
        shift_reg   <= {1'b1, shift_reg[8:1]};
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/buff_uart_reader.sv
// buff_uart_reader: on each write_done, sends SYNC followed by every byte of
// the completed buffer page over an 8N1 UART line.
// Ports:
//  clk        in  system clock
//  res        in  asynchronous reset, active high
//  write_done in  1-clk pulse: a full page is ready
//  buf_dout   in  buffer data, valid 1 clk after read_addr changes
//  read_addr  out buffer read address
//  TXD        out UART serial out, idle high
//  busy       out a frame is being sent
//  page_sent  out 1-clk pulse once the last page byte has left the line
//  overrun    out sticky: write_done seen while busy
module buff_uart_reader
  import buff_uart_reader_pkg::*;
#(
  parameter int         CLK_DIV = 434,
  parameter int         NBYTES  = 256,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       res,
  input  logic       write_done,
  input  logic [7:0] buf_dout,
  output logic [7:0] read_addr,
  output logic       TXD,
  output logic       busy,
  output logic       page_sent,
  output logic       overrun
);

  localparam logic [7:0] LAST_ADDR = 8'(NBYTES - 1);

  state_t     state_reg, state_next;
  logic [7:0] addr_reg, addr_next;
  logic       busy_reg, busy_next;
  logic       overrun_reg, overrun_next;
  logic       sync_reg, sync_next;   // byte in flight is the header, not page data
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .res      (res),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .TXD      (TXD),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      sync_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      busy_reg    <= busy_next;
      overrun_reg <= overrun_next;
      sync_reg    <= sync_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    busy_next    = busy_reg;
    sync_next    = sync_reg;
    // busy is still high during DONE, so a request in that clk is an overrun.
    overrun_next = overrun_reg | (write_done & busy_reg);
    tx_start     = 1'b0;
    tx_data      = buf_dout;
    case (state_reg)
      ST_IDLE: begin
        if (write_done) begin
          busy_next  = 1'b1;
          addr_next  = '0;
          state_next = ST_LOAD_SYNC;
        end
      end
      ST_LOAD_SYNC: begin
        tx_data = SYNC;
        if (!tx_busy) begin
          tx_start   = 1'b1;
          sync_next  = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_FETCH: state_next = ST_LATCH;   // one clk of buffer read latency
      ST_LATCH: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          sync_next  = 1'b0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          state_next = (sync_reg || (addr_reg < LAST_ADDR)) ? ST_NEXT : ST_DONE;
        end
      end
      ST_NEXT: begin
        // After the header, address 0 is still the next byte to fetch.
        if (!sync_reg) begin
          addr_next = addr_reg + 8'd1;
        end
        state_next = ST_FETCH;
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        addr_next  = '0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign read_addr = addr_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;
  assign page_sent = (state_reg == ST_DONE);

endmodule

// File: tb/tb_buff_uart_reader.sv
// Self-checking bench for buff_uart_reader: a CLK_DIV=4 and a CLK_DIV=2
// instance, a 1-clk-latency buffer model, an expected-byte queue filled at
// stimulus time and a UART decoder that pops and compares each received byte.
module tb_buff_uart_reader;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       wd0 = 1'b0, wd1 = 1'b0;
  logic [7:0] dout0, dout1, addr0, addr1;
  logic       txd0, txd1, busy0, busy1, ps0, ps1, ovr0, ovr1;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  buff_uart_reader #(.CLK_DIV(4), .NBYTES(256), .SYNC(8'hA5)) dut0 (
    .clk(clk), .res(res), .write_done(wd0), .buf_dout(dout0), .read_addr(addr0),
    .TXD(txd0), .busy(busy0), .page_sent(ps0), .overrun(ovr0));

  buff_uart_reader #(.CLK_DIV(2), .NBYTES(256), .SYNC(8'hA5)) dut1 (
    .clk(clk), .res(res), .write_done(wd1), .buf_dout(dout1), .read_addr(addr1),
    .TXD(txd1), .busy(busy1), .page_sent(ps1), .overrun(ovr1));

  // Page buffer: registered read, data valid one clk after the address.
  always @(posedge clk) begin
    dout0 <= mem[addr0];
    dout1 <= mem[addr1];
  end

  int         total = 0;
  int         bad = 0;
  int         sel = 0;          // 0: watch dut0, 1: watch dut1
  int         ps_cnt = 0;
  int         frame_pos = 0;    // bytes received in the current frame
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // UART decoder: samples every clk, checks each bit holds for the full
  // bit time, pops the expected queue on each completed character.
  bit       cap_on = 1'b0;
  int       cap_cnt = 0;
  int       gap = 0;
  bit [9:0] bitv;
  bit       width_err;

  always @(negedge clk) begin
    logic       t;
    int         dv;
    logic [7:0] e;
    t  = (sel != 0) ? txd1 : txd0;
    dv = (sel != 0) ? 2 : 4;
    if (ps0 || ps1) ps_cnt++;
    if (res) begin
      cap_on    = 1'b0;
      frame_pos = 0;
      gap       = 0;
    end else if (!cap_on) begin
      if (t == 1'b0) begin
        if (frame_pos != 0) begin
          total++;
          if (gap > 3) begin
            bad++;
            $display("FAIL inter_byte_gap: got=%0d clks required<=3", gap);
          end
        end
        cap_on    = 1'b1;
        cap_cnt   = 1;
        bitv      = '0;
        width_err = 1'b0;
      end else begin
        gap++;
      end
    end else begin
      if (cap_cnt % dv == 0) bitv[cap_cnt / dv] = t;
      else if (bitv[cap_cnt / dv] != t) width_err = 1'b1;
      cap_cnt++;
      if (cap_cnt == 10 * dv) begin
        cap_on = 1'b0;
        gap    = 0;
        chk("stop_bit", int'(bitv[9]), 1);
        chk("bit_width", int'(width_err), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got=%02h required=none", bitv[8:1]);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", int'(bitv[8:1]), int'(e));
        end
        frame_pos = (frame_pos == 256) ? 0 : frame_pos + 1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input bit pattern);
    for (int i = 0; i < 256; i++)
      mem[i] = pattern ? (8'(i) ^ 8'h3C) : 8'($urandom);
  endtask

  // Reference: an accepted request yields SYNC then the whole page in order.
  task automatic start_frame();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[i]);
    if (sel != 0) wd1 = 1'b1; else wd0 = 1'b1;
    @(negedge clk);
    wd0 = 1'b0;
    wd1 = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ((sel != 0) ? busy1 : busy0)) && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < 12000), 1);
    if (n >= 12000) exp_q.delete();
    cycles(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol, psb, n;

    // 1: reset, then quiet idle
    #1 res = 1'b1;
    cycles(3);
    res  = 1'b0;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || busy0 !== 1'b0 || addr0 !== 8'd0 || ps0 !== 1'b0 ||
          ovr0 !== 1'b0 || txd1 !== 1'b1 || busy1 !== 1'b0 || ps1 !== 1'b0) viol++;
    end
    chk("t1_idle_quiet", viol, 0);
    chk("t1_txd", int'(txd0), 1);
    chk("t1_read_addr", int'(addr0), 0);

    // 2: reference pattern page
    sel = 0;
    fill(1'b1);
    psb = ps_cnt;
    start_frame();
    wait_frame("t2_frame_done");
    chk("t2_page_sent", ps_cnt - psb, 1);
    chk("t2_busy_low", int'(busy0), 0);
    chk("t2_read_addr", int'(addr0), 0);
    chk("t2_overrun", int'(ovr0), 0);

    // 3: second request mid-frame is an overrun, frame unaffected
    fill(1'b0);
    psb = ps_cnt;
    start_frame();
    cycles($urandom_range(550, 450));
    wd0 = 1'b1;
    @(negedge clk);
    wd0 = 1'b0;
    cycles(1);
    chk("t3_overrun_set", int'(ovr0), 1);
    wait_frame("t3_frame_done");
    chk("t3_page_sent", ps_cnt - psb, 1);
    cycles(200);
    chk("t3_no_restart", ps_cnt - psb, 1);
    chk("t3_busy_low", int'(busy0), 0);
    chk("t3_overrun_sticky", int'(ovr0), 1);

    // 4: reset in the middle of byte 10
    fill(1'b0);
    psb = ps_cnt;
    start_frame();
    n = 0;
    while (frame_pos < 10 && n < 2000) begin @(negedge clk); n++; end
    cycles($urandom_range(30, 0));
    while (txd0 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    chk("t4_reached_byte10", int'(n < 3000), 1);
    #2 res = 1'b1;
    #1;
    chk("t4_txd_async", int'(txd0), 1);
    chk("t4_busy_cleared", int'(busy0), 0);
    chk("t4_overrun_cleared", int'(ovr0), 0);
    exp_q.delete();
    cycles(3);
    res = 1'b0;
    chk("t4_no_page_sent", ps_cnt - psb, 0);

    // 4/5: full frame after reset; request landing in the DONE clk
    fill(1'b0);
    psb = ps_cnt;
    start_frame();
    n = 0;
    while (ps0 !== 1'b1 && n < 12000) begin @(negedge clk); n++; end
    chk("t5_done_seen", int'(n < 12000), 1);
    wd0 = 1'b1;
    @(negedge clk);
    wd0 = 1'b0;
    wait_frame("t4_frame_done");
    chk("t4_page_sent", ps_cnt - psb, 1);
    chk("t5_overrun_set", int'(ovr0), 1);
    cycles(150);
    chk("t5_no_restart", ps_cnt - psb, 1);
    chk("t5_busy_low", int'(busy0), 0);

    fill(1'b0);
    psb = ps_cnt;
    start_frame();
    wait_frame("t5_frame_done");
    chk("t5_page_sent", ps_cnt - psb, 1);
    chk("t5_read_addr", int'(addr0), 0);
    chk("t5_overrun_sticky", int'(ovr0), 1);

    // 6: CLK_DIV=2 instance, two consecutive pages
    sel = 1;
    cycles(5);
    psb = ps_cnt;
    fill(1'b0);
    start_frame();
    wait_frame("t6_frame1_done");
    fill(1'b0);
    start_frame();
    wait_frame("t6_frame2_done");
    chk("t6_page_sent", ps_cnt - psb, 2);
    chk("t6_busy_low", int'(busy1), 0);
    chk("t6_read_addr", int'(addr1), 0);
    chk("t6_overrun", int'(ovr1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
